// File: rtl/io_pkg.sv
// Shared definitions for the IO port controller: FSM encodings and seven-segment patterns.
// Segment patterns are active-low in gfedcba order.
package io_pkg;

    typedef enum logic [1:0] {
        IN_IDLE,
        IN_WAIT,
        IN_ACK
    } in_state_e;

    typedef enum logic {
        D_IDLE,
        D_CONV
    } disp_state_e;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    function automatic logic [6:0] seg7(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = 7'b1000000;
            4'h1:    seg = 7'b1111001;
            4'h2:    seg = 7'b0100100;
            4'h3:    seg = 7'b0110000;
            4'h4:    seg = 7'b0011001;
            4'h5:    seg = 7'b0010010;
            4'h6:    seg = 7'b0000010;
            4'h7:    seg = 7'b1111000;
            4'h8:    seg = 7'b0000000;
            4'h9:    seg = 7'b0010000;
            4'hA:    seg = 7'b0001000;
            4'hB:    seg = 7'b0000011;
            4'hC:    seg = 7'b1000110;
            4'hD:    seg = 7'b0100001;
            4'hE:    seg = 7'b0000110;
            default: seg = 7'b0001110;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential shift-add-3 binary to BCD converter, one input bit per cycle.
// The first bit is taken on the start edge so done fires DATA_W-1 cycles after start.
module bin2bcd_seq #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned N_DIGITS = 8
) (
    input  logic                    CLK,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    abort,
    input  logic [DATA_W-1:0]       bin,
    output logic                    busy,
    output logic                    done,
    output logic                    overflow,
    output logic [4*N_DIGITS-1:0]   bcd
);

    // 0.31 >= log10(2), so this always covers every decimal digit of a DATA_W-bit value
    localparam int unsigned FULL_DIGITS = (DATA_W * 31) / 100 + 1;
    localparam int unsigned NB          = (FULL_DIGITS > N_DIGITS) ? FULL_DIGITS : N_DIGITS;
    localparam int unsigned CNT_W       = $clog2(DATA_W + 1);

    logic [DATA_W-1:0] sh_q;
    logic [4*NB-1:0]   acc_q;
    logic [4*NB-1:0]   acc_adj;
    logic [4*NB-1:0]   acc_step;
    logic [CNT_W-1:0]  cnt_q;

    always_comb begin
        acc_adj = acc_q;
        for (int unsigned i = 0; i < NB; i++) begin
            if (acc_q[4*i +: 4] >= 4'd5) begin
                acc_adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
            end
        end
        acc_step = {acc_adj[4*NB-2:0], sh_q[DATA_W-1]};
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            sh_q  <= '0;
            acc_q <= '0;
            cnt_q <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (abort) begin
                busy <= 1'b0;
            end else if (start) begin
                acc_q <= {{(4*NB-1){1'b0}}, bin[DATA_W-1]};
                sh_q  <= bin << 1;
                cnt_q <= CNT_W'(DATA_W - 1);
                busy  <= (DATA_W > 1);
                done  <= (DATA_W == 1);
            end else if (busy) begin
                acc_q <= acc_step;
                sh_q  <= sh_q << 1;
                cnt_q <= cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

    assign bcd = acc_q[4*N_DIGITS-1:0];

    always_comb begin
        overflow = 1'b0;
        for (int unsigned i = 4*N_DIGITS; i < 4*NB; i++) begin
            overflow = overflow | acc_q[i];
        end
    end

endmodule

// File: rtl/io_port_ctrl.sv
// Processor IO port: stalls for a debounced user confirm on input instructions and drives
// a seven-segment display (hex or decimal) on output instructions.
module io_port_ctrl
    import io_pkg::*;
#(
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned SW_W         = 15,
    parameter int unsigned N_DIGITS     = 8,
    parameter int unsigned DEBOUNCE_CYC = 16
) (
    input  logic                    CLK,
    input  logic                    reset,
    input  logic                    in_req,
    input  logic                    out_req,
    input  logic [DATA_W-1:0]       out_data,
    input  logic                    dec_mode,
    input  logic [SW_W-1:0]         SW,
    input  logic                    insert,
    output logic [DATA_W-1:0]       in_data,
    output logic                    in_valid,
    output logic                    stall,
    output logic [7*N_DIGITS-1:0]   HEX
);

    localparam int unsigned DB_CNT_W = $clog2(DEBOUNCE_CYC + 1);

    logic [DB_CNT_W-1:0] db_cnt_q;
    logic                db_q;
    logic                db_prev_q;
    logic                ins_rise;
    in_state_e           in_state_q;
    disp_state_e         disp_state_q;

    logic                    conv_start;
    logic                    conv_abort;
    logic                    conv_busy;
    logic                    conv_done;
    logic                    conv_ovf;
    logic [4*N_DIGITS-1:0]   conv_bcd;
    logic [7*N_DIGITS-1:0]   hex_direct;
    logic [7*N_DIGITS-1:0]   hex_dec;
    logic [4*N_DIGITS+DATA_W-1:0] wide_data;

    // Debounce: level flips only after DEBOUNCE_CYC consecutive differing samples
    always_ff @(posedge CLK) begin
        if (reset) begin
            db_cnt_q  <= '0;
            db_q      <= 1'b0;
            db_prev_q <= 1'b0;
        end else begin
            db_prev_q <= db_q;
            if (insert == db_q) begin
                db_cnt_q <= '0;
            end else if (db_cnt_q == DB_CNT_W'(DEBOUNCE_CYC - 1)) begin
                db_q     <= insert;
                db_cnt_q <= '0;
            end else begin
                db_cnt_q <= db_cnt_q + DB_CNT_W'(1);
            end
        end
    end

    // A press already held on entry shows no rise, so it needs release and re-press
    assign ins_rise = db_q & ~db_prev_q;

    always_ff @(posedge CLK) begin
        if (reset) begin
            in_state_q <= IN_IDLE;
            stall      <= 1'b0;
            in_valid   <= 1'b0;
            in_data    <= '0;
        end else begin
            in_valid <= 1'b0;
            case (in_state_q)
                IN_IDLE: begin
                    if (in_req) begin
                        in_state_q <= IN_WAIT;
                        stall      <= 1'b1;
                    end
                end
                IN_WAIT: begin
                    if (ins_rise) begin
                        in_data    <= DATA_W'(SW);
                        in_valid   <= 1'b1;
                        stall      <= 1'b0;
                        in_state_q <= IN_ACK;
                    end
                end
                IN_ACK: begin
                    in_state_q <= IN_IDLE;
                end
                default: begin
                    in_state_q <= IN_IDLE;
                    stall      <= 1'b0;
                end
            endcase
        end
    end

    assign conv_start = out_req & dec_mode;
    assign conv_abort = out_req & ~dec_mode;

    bin2bcd_seq #(
        .DATA_W   (DATA_W),
        .N_DIGITS (N_DIGITS)
    ) u_bin2bcd (
        .CLK      (CLK),
        .reset    (reset),
        .start    (conv_start),
        .abort    (conv_abort),
        .bin      (out_data),
        .busy     (conv_busy),
        .done     (conv_done),
        .overflow (conv_ovf),
        .bcd      (conv_bcd)
    );

    // Zero-extension makes digits beyond the data width show 0
    assign wide_data = {{(4*N_DIGITS){1'b0}}, out_data};

    always_comb begin
        hex_direct = '0;
        hex_dec    = '0;
        for (int unsigned i = 0; i < N_DIGITS; i++) begin
            hex_direct[7*i +: 7] = seg7(wide_data[4*i +: 4]);
            hex_dec[7*i +: 7]    = conv_ovf ? SEG_DASH : seg7(conv_bcd[4*i +: 4]);
        end
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            disp_state_q <= D_IDLE;
            HEX          <= {N_DIGITS{SEG_BLANK}};
        end else if (out_req) begin
            if (dec_mode) begin
                disp_state_q <= D_CONV;
            end else begin
                disp_state_q <= D_IDLE;
                HEX          <= hex_direct;
            end
        end else begin
            case (disp_state_q)
                D_IDLE: disp_state_q <= D_IDLE;
                D_CONV: begin
                    if (conv_done) begin
                        HEX          <= hex_dec;
                        disp_state_q <= D_IDLE;
                    end else if (!conv_busy) begin
                        disp_state_q <= D_IDLE;
                    end
                end
                default: disp_state_q <= D_IDLE;
            endcase
        end
    end

endmodule

// File: doc/io_port_ctrl.md
IO_PORT_CTRL -- requirements
Module: io_port_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 32, datapath width of processor register values.
REQ-002 SHALL have parameter SW_W, default 15, number of user switches.
REQ-003 SHALL have parameter N_DIGITS, default 8, number of seven-segment digits driven.
REQ-004 SHALL have parameter DEBOUNCE_CYC, default 16, cycles `insert` must be stable before a level change is accepted.
REQ-005 SHALL have port CLK  input  1  sole clock; all state updates on its rising edge.
REQ-006 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-007 SHALL have port in_req  input  1  input instruction executing (from control unit).
REQ-008 SHALL have port out_req  input  1  output instruction executing.
REQ-009 SHALL have port out_data  input  DATA_W  value to display, sampled when out_req=1.
REQ-010 SHALL have port dec_mode  input  1  1 = unsigned decimal display, 0 = hexadecimal.
REQ-011 SHALL have port SW  input  SW_W  user switch value.
REQ-012 SHALL have port insert  input  1  raw user confirm button, active-high.
REQ-013 SHALL have port in_data  output  DATA_W  captured user value, zero-extended SW.
REQ-014 SHALL have port in_valid  output  1  one-cycle pulse, in_data newly captured.
REQ-015 SHALL have port stall  output  1  freeze processor clock-enable/PC while waiting for user.
REQ-016 SHALL have port HEX  output  7*N_DIGITS  active-low segments, digit i at bits [7i+6:7i], segment order gfedcba.

Function
REQ-017 SHALL run two independent state machines: input FSM {IN_IDLE, IN_WAIT, IN_ACK} and display FSM {D_IDLE, D_CONV}.
REQ-018 Input FSM SHALL go IN_IDLE -> IN_WAIT on the cycle after in_req=1, asserting stall from that cycle (registered).
REQ-019 In IN_WAIT, only a debounced rising edge of insert occurring while in IN_WAIT SHALL be accepted; a press already held on entry SHALL require release then re-press.
REQ-020 Debounced insert SHALL change level only after the raw input has differed from it for DEBOUNCE_CYC consecutive cycles; any glitch restarts the count.
REQ-021 On acceptance, SW SHALL be captured zero-extended into in_data; next state IN_ACK.
REQ-022 In IN_ACK, in_valid=1 and stall=0 for exactly one cycle, then IN_IDLE; in_req ignored in IN_ACK.
REQ-023 Display FSM: out_req=1 SHALL capture out_data; hex mode loads HEX directly next cycle (low N_DIGITS nibbles, digits above DATA_W/4 show 0).
REQ-024 Decimal mode SHALL enter D_CONV running sequential shift-add-3 conversion, one bit per cycle, HEX updated exactly DATA_W+1 cycles after out_req; HEX holds old value meanwhile.
REQ-025 A new out_req during D_CONV SHALL abort and restart with the new value (latest wins).
REQ-026 If decimal value >= 10^N_DIGITS, all digits SHALL show dash (7'b0111111).
REQ-027 Display FSM SHALL never assert stall; in_req and out_req in the same cycle SHALL both be serviced.
REQ-028 dec_mode SHALL be sampled only with out_req; later changes do not alter the displayed value.

Reset
REQ-029 reset=1 at a clock edge SHALL force IN_IDLE, D_IDLE, stall=0, in_valid=0, in_data=0, HEX all blank (all ones), debounce counter 0, debounced insert 0.
REQ-030 reset mid-wait or mid-conversion SHALL abandon the operation with no in_valid pulse and no HEX update.

Structure
REQ-031 Shared package io_pkg SHALL hold the FSM state encodings, seven-segment digit table (0-F), SEG_BLANK and SEG_DASH constants.
REQ-032 Binary-to-BCD conversion SHALL be a sub-module bin2bcd_seq (start/busy/done, parameterised DATA_W, N_DIGITS, overflow flag).

Verification
REQ-033 in_req pulse, SW=15'h1234, insert held 20 cycles -> stall high until accept, in_valid one cycle, in_data=32'h1234, stall low.
REQ-034 insert glitch of 5 cycles in IN_WAIT -> no acceptance, stall stays 1.
REQ-035 out_req, dec_mode=1, out_data=12345678 -> after 33 cycles HEX shows 1,2,3,4,5,6,7,8 digits 7..0.
REQ-036 out_req dec_mode=1 data=100000000 -> all digits dash; out_req dec_mode=0 data=32'hDEADBEEF -> next cycle D,E,A,D,B,E,E,F.
REQ-037 second out_req (data=42) 10 cycles into conversion of 999 -> final display 00000042, 999 never shown.
REQ-038 reset asserted in IN_WAIT -> next cycle stall=0, HEX blank, no in_valid pulse.
